// File: rtl/dpram_delay_pkg.sv
// Shared types and helpers for the dpram_delay_ctrl audio delay line.
// The echo-mix option is selected by the DPRAM_DELAY_ECHO_MIX_EN macro.
package dpram_delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int GAIN_W     = 8;
    localparam int GAIN_SHIFT = 8;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                      input int              w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/dpram_delay_mix.sv
// Echo mixer: sample + ((delayed * gain) >>> 8), saturated to DATA_W bits.
// Only present when DPRAM_DELAY_ECHO_MIX_EN is defined.
`ifdef DPRAM_DELAY_ECHO_MIX_EN
module dpram_delay_mix
    import dpram_delay_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [DATA_W-1:0] delayed,
    input  logic        [GAIN_W-1:0] gain,
    output logic signed [DATA_W-1:0] mixed
);

    logic signed [DATA_W+GAIN_W:0] product;
    logic signed [DATA_W:0]        scaled;
    logic signed [DATA_W:0]        sum;
    logic signed [31:0]            sat_val;

    always_comb begin
        // Gain is unsigned, so widen it with a zero sign bit before the signed multiply.
        product = delayed * $signed({1'b0, gain});
        scaled  = product[DATA_W+GAIN_W:GAIN_SHIFT];
        sum     = {sample[DATA_W-1], sample} + scaled;
        sat_val = sat_signed(32'(sum), DATA_W);
        mixed   = sat_val[DATA_W-1:0];
    end

endmodule
`endif

// File: rtl/dpram_delay_ctrl.sv
// Circular-buffer delay line driving a 1-cycle-latency true dual-port RAM.
// Define DPRAM_DELAY_ECHO_MIX_EN to mix the delayed sample back onto the input.
module dpram_delay_ctrl
    import dpram_delay_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int RAM_DW = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [ADDR_W-1:0] delay,
    input  logic [GAIN_W-1:0] gain,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] ram_a_addr,
    output logic [RAM_DW-1:0] ram_a_wr_data,
    output logic              ram_a_wr_en,
    output logic [ADDR_W-1:0] ram_b_addr,
    input  logic [RAM_DW-1:0] ram_b_rd_data,
    output logic              ram_b_wr_en,
    output logic [RAM_DW-1:0] ram_b_wr_data
);

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  sample_reg;
    logic [ADDR_W-1:0]  d_reg;
    logic [ADDR_W-1:0]  wr_ptr_reg;
    logic [ADDR_W-1:0]  fill_cnt_reg;
    logic               s_ready_reg;
    logic               m_valid_reg;
    logic [DATA_W-1:0]  m_data_reg;
    logic [ADDR_W-1:0]  ram_a_addr_reg;
    logic [RAM_DW-1:0]  ram_a_wr_data_reg;
    logic               ram_a_wr_en_reg;
    logic [ADDR_W-1:0]  ram_b_addr_reg;

    logic               accept;
    logic [ADDR_W-1:0]  d_eff;
    logic [DATA_W-1:0]  delayed;
    logic [DATA_W-1:0]  result;

    assign accept = (state_reg == IDLE) && s_valid && s_ready_reg;
    assign d_eff  = (delay == '0) ? ADDR_W'(1) : delay;

    // RAM contents are uninitialised, so anything older than what we have written reads as silence.
    assign delayed = (fill_cnt_reg < d_reg) ? '0 : ram_b_rd_data[DATA_W-1:0];

`ifdef DPRAM_DELAY_ECHO_MIX_EN
    logic [DATA_W-1:0] mixed;

    dpram_delay_mix #(.DATA_W(DATA_W)) u_mix (
        .sample  (sample_reg),
        .delayed (delayed),
        .gain    (gain),
        .mixed   (mixed)
    );

    assign result = mixed;
`else
    assign result = delayed;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = OUT;
            OUT:     if (m_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clr) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            sample_reg        <= '0;
            d_reg             <= '0;
            wr_ptr_reg        <= '0;
            fill_cnt_reg      <= '0;
            s_ready_reg       <= 1'b0;
            m_valid_reg       <= 1'b0;
            m_data_reg        <= '0;
            ram_a_addr_reg    <= '0;
            ram_a_wr_data_reg <= '0;
            ram_a_wr_en_reg   <= 1'b0;
            ram_b_addr_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            s_ready_reg     <= (state_next == IDLE);
            ram_a_wr_en_reg <= 1'b0;
            if (clr) begin
                wr_ptr_reg   <= '0;
                fill_cnt_reg <= '0;
                m_valid_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            sample_reg        <= s_data;
                            d_reg             <= d_eff;
                            ram_a_addr_reg    <= wr_ptr_reg;
                            ram_a_wr_data_reg <= RAM_DW'(s_data);
                            ram_a_wr_en_reg   <= 1'b1;
                            ram_b_addr_reg    <= wr_ptr_reg - d_eff;
                        end
                    end
                    WAIT: begin
                        wr_ptr_reg  <= wr_ptr_reg + ADDR_W'(1);
                        if (fill_cnt_reg != '1) begin
                            fill_cnt_reg <= fill_cnt_reg + ADDR_W'(1);
                        end
                        m_data_reg  <= result;
                        m_valid_reg <= 1'b1;
                    end
                    OUT: begin
                        if (m_ready) begin
                            m_valid_reg <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_ready       = s_ready_reg;
    assign m_valid       = m_valid_reg;
    assign m_data        = m_data_reg;
    assign ram_a_addr    = ram_a_addr_reg;
    assign ram_a_wr_data = ram_a_wr_data_reg;
    assign ram_a_wr_en   = ram_a_wr_en_reg;
    assign ram_b_addr    = ram_b_addr_reg;
    assign ram_b_wr_en   = 1'b0;
    assign ram_b_wr_data = '0;

    // Upper RAM bits, gain and the latched sample only matter in some builds.
    logic unused_ok;
    assign unused_ok = ^{ram_b_rd_data, gain, sample_reg, 32'(GAIN_SHIFT)};

endmodule
